// File: rtl/nap_timer.sv
// ============================================================================
// Module   : nap_timer
// Purpose  : Nap-controller responder. Collects a 2-digit minute value from a
//            one-hot keypad, then counts it down to 00:00 with a 1 s tick.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nap_timer #(
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int MAX_MIN       = 99
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic       i_init,
    input  wire logic       i_enSetting,
    input  wire logic       i_enSleep,
    input  wire logic       i_enCancel,
    input  wire logic [9:0] i_keypad,
    input  wire logic       i_sharp,
    output logic            o_completeSetting,
    output logic            o_completeSleep,
    output logic [6:0]      o_remaining_min,
    output logic [5:0]      o_remaining_sec,
    output logic            o_entry_err
);

    localparam int C_PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [C_PW-1:0] C_PRESC_LAST = C_PW'(TICKS_PER_SEC - 1);
    localparam logic [6:0]      C_MAX_MIN    = 7'(MAX_MIN);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ENTRY  = 3'd1;
    localparam logic [2:0] S_LOADED = 3'd2;
    localparam logic [2:0] S_COUNT  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]      r_state;
    logic [2:0]      w_next_state;

    logic            r_key_prev;
    logic            r_sharp_prev;
    logic            r_init_prev;
    logic            r_cancel_prev;

    logic [3:0]      r_tens;
    logic [3:0]      r_ones;
    logic [6:0]      r_min;
    logic [5:0]      r_sec;
    logic [C_PW-1:0] r_presc;
    logic            r_entry_err;

    logic            w_abort;
    logic            w_key_evt;
    logic            w_sharp_evt;
    logic            w_key_onehot;
    logic [3:0]      w_digit;
    logic [6:0]      w_value;
    logic            w_value_ok;
    logic            w_tick;
    logic            w_last_sec;

    // ------------------------------------------------------------------------
    // Event detection
    // ------------------------------------------------------------------------
    assign w_abort      = (i_init & ~r_init_prev) | (i_enCancel & ~r_cancel_prev);
    assign w_key_onehot = ((i_keypad & (i_keypad - 10'd1)) == 10'd0);
    assign w_key_evt    = (i_keypad != 10'd0) & ~r_key_prev & w_key_onehot;
    assign w_sharp_evt  = i_sharp & ~r_sharp_prev;

    always_comb begin
        w_digit = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (i_keypad[i]) begin
                w_digit = 4'(i);
            end
        end
    end

    assign w_value    = ({3'd0, r_tens} * 7'd10) + {3'd0, r_ones};
    assign w_value_ok = (w_value != 7'd0) && (w_value <= C_MAX_MIN);
    assign w_tick     = (r_state == S_COUNT) && (r_presc == C_PRESC_LAST);
    assign w_last_sec = (r_min == 7'd0) && (r_sec == 6'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key_prev    <= 1'b0;
            r_sharp_prev  <= 1'b0;
            r_init_prev   <= 1'b0;
            r_cancel_prev <= 1'b0;
        end else begin
            r_key_prev    <= (i_keypad != 10'd0);
            r_sharp_prev  <= i_sharp;
            r_init_prev   <= i_init;
            r_cancel_prev <= i_enCancel;
        end
    end

    // ------------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (w_abort) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_enSetting) begin
                        w_next_state = S_ENTRY;
                    end
                end
                S_ENTRY: begin
                    if (w_sharp_evt && w_value_ok) begin
                        w_next_state = S_LOADED;
                    end
                end
                S_LOADED: begin
                    if (i_enSleep) begin
                        w_next_state = S_COUNT;
                    end
                end
                S_COUNT: begin
                    if (w_tick && w_last_sec) begin
                        w_next_state = S_DONE;
                    end
                end
                S_DONE:  w_next_state = S_DONE;
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    always_comb begin
        o_completeSetting = 1'b0;
        o_completeSleep   = 1'b0;
        o_remaining_min   = r_min;
        o_remaining_sec   = r_sec;
        o_entry_err       = r_entry_err;
        case (r_state)
            S_ENTRY: begin
                o_remaining_min = w_value;
                o_remaining_sec = 6'd0;
            end
            S_LOADED, S_COUNT: begin
                o_completeSetting = 1'b1;
            end
            S_DONE: begin
                o_completeSetting = 1'b1;
                o_completeSleep   = 1'b1;
            end
            default: begin
                o_completeSetting = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath: digit entry, prescaler and countdown registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tens      <= 4'd0;
            r_ones      <= 4'd0;
            r_min       <= 7'd0;
            r_sec       <= 6'd0;
            r_presc     <= '0;
            r_entry_err <= 1'b0;
        end else if (w_abort) begin
            r_tens      <= 4'd0;
            r_ones      <= 4'd0;
            r_min       <= 7'd0;
            r_sec       <= 6'd0;
            r_presc     <= '0;
            r_entry_err <= 1'b0;
        end else begin
            r_entry_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_enSetting) begin
                        r_tens <= 4'd0;
                        r_ones <= 4'd0;
                    end
                end
                S_ENTRY: begin
                    // A confirm in the same cycle as a key press discards the key.
                    if (w_sharp_evt) begin
                        if (w_value_ok) begin
                            r_min <= w_value;
                            r_sec <= 6'd0;
                        end else begin
                            r_entry_err <= 1'b1;
                            r_tens      <= 4'd0;
                            r_ones      <= 4'd0;
                        end
                    end else if (w_key_evt) begin
                        r_tens <= r_ones;
                        r_ones <= w_digit;
                    end
                end
                S_LOADED: begin
                    if (i_enSleep) begin
                        r_presc <= '0;
                    end
                end
                S_COUNT: begin
                    if (w_tick) begin
                        r_presc <= '0;
                        if (w_last_sec) begin
                            r_sec <= 6'd0;
                        end else if (r_sec != 6'd0) begin
                            r_sec <= r_sec - 6'd1;
                        end else if (r_min != 7'd0) begin
                            r_min <= r_min - 7'd1;
                            r_sec <= 6'd59;
                        end
                    end else begin
                        r_presc <= r_presc + 1'b1;
                    end
                end
                default: begin
                    r_presc <= r_presc;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_nap_timer.sv
// Directed bench for nap_timer with a 4-cycle second.
`default_nettype none

module tb_nap_timer;

    logic       clk;
    logic       rst_n;
    logic       init;
    logic       enSetting;
    logic       enSleep;
    logic       enCancel;
    logic [9:0] keypad;
    logic       sharp;
    logic       completeSetting;
    logic       completeSleep;
    logic [6:0] remaining_min;
    logic [5:0] remaining_sec;
    logic       entry_err;

    int checks = 0;
    int errors = 0;

    nap_timer #(.TICKS_PER_SEC(4), .MAX_MIN(99)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_init            (init),
        .i_enSetting       (enSetting),
        .i_enSleep         (enSleep),
        .i_enCancel        (enCancel),
        .i_keypad          (keypad),
        .i_sharp           (sharp),
        .o_completeSetting (completeSetting),
        .o_completeSleep   (completeSleep),
        .o_remaining_min   (remaining_min),
        .o_remaining_sec   (remaining_sec),
        .o_entry_err       (entry_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic press_key(input int d);
        @(negedge clk);
        keypad = 10'd1 << d;
        @(negedge clk);
        keypad = 10'd0;
    endtask

    task automatic press_sharp();
        @(negedge clk);
        sharp = 1'b1;
        @(negedge clk);
        sharp = 1'b0;
    endtask

    task automatic cancel();
        @(negedge clk);
        enSetting = 1'b0;
        enSleep   = 1'b0;
        enCancel  = 1'b1;
        @(negedge clk);
        enCancel  = 1'b0;
    endtask

    task automatic start_entry();
        @(negedge clk);
        enSetting = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1;
        if ({completeSetting, completeSleep, entry_err} !== 3'b000) begin
            errors++; $display("FAIL reset_flags got %b want 000", {completeSetting, completeSleep, entry_err});
        end
        checks++;
        if ({remaining_min, remaining_sec} !== 13'd0) begin
            errors++; $display("FAIL reset_time got %0d:%0d want 0:0", remaining_min, remaining_sec);
        end
        checks++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_entry();
        start_entry();
        press_key(1); press_key(2); press_key(5);
        if (remaining_min !== 7'd25) begin
            errors++; $display("FAIL entry_value got %0d want 25", remaining_min);
        end
        checks++;
        if (completeSetting !== 1'b0) begin
            errors++; $display("FAIL entry_cs_early got %b want 0", completeSetting);
        end
        checks++;
        @(negedge clk);
        sharp = 1'b1;
        @(negedge clk);
        sharp = 1'b0;
        if (completeSetting !== 1'b1) begin
            errors++; $display("FAIL entry_cs got %b want 1", completeSetting);
        end
        checks++;
        if (entry_err !== 1'b0) begin
            errors++; $display("FAIL entry_err_clean got %b want 0", entry_err);
        end
        checks++;
        if (remaining_min !== 7'd25) begin
            errors++; $display("FAIL loaded_value got %0d want 25", remaining_min);
        end
        checks++;
        cancel();
    endtask

    task automatic test_entry_error();
        start_entry();
        press_key(0);
        @(negedge clk);
        sharp = 1'b1;
        @(negedge clk);
        sharp = 1'b0;
        if (entry_err !== 1'b1) begin
            errors++; $display("FAIL err_pulse got %b want 1", entry_err);
        end
        checks++;
        if (completeSetting !== 1'b0) begin
            errors++; $display("FAIL err_cs got %b want 0", completeSetting);
        end
        checks++;
        @(negedge clk);
        if (entry_err !== 1'b0) begin
            errors++; $display("FAIL err_pulse_width got %b want 0", entry_err);
        end
        checks++;
        keypad = 10'd1 << 3;
        repeat (10) @(negedge clk);
        keypad = 10'd0;
        @(negedge clk);
        if (remaining_min !== 7'd3) begin
            errors++; $display("FAIL held_key got %0d want 3", remaining_min);
        end
        checks++;
        keypad = 10'b0000000011;
        @(negedge clk);
        keypad = 10'd0;
        @(negedge clk);
        if (remaining_min !== 7'd3) begin
            errors++; $display("FAIL multi_key got %0d want 3", remaining_min);
        end
        checks++;
        if (completeSetting !== 1'b0) begin
            errors++; $display("FAIL still_entry got %b want 0", completeSetting);
        end
        checks++;
        cancel();
    endtask

    task automatic test_countdown();
        start_entry();
        press_key(2);
        press_sharp();
        enSetting = 1'b0;
        enSleep   = 1'b1;
        @(negedge clk);
        if ({remaining_min, remaining_sec} !== {7'd2, 6'd0}) begin
            errors++; $display("FAIL count_start got %0d:%0d want 2:0", remaining_min, remaining_sec);
        end
        checks++;
        repeat (3) @(negedge clk);
        if ({remaining_min, remaining_sec} !== {7'd2, 6'd0}) begin
            errors++; $display("FAIL count_3cyc got %0d:%0d want 2:0", remaining_min, remaining_sec);
        end
        checks++;
        @(negedge clk);
        if ({remaining_min, remaining_sec} !== {7'd1, 6'd59}) begin
            errors++; $display("FAIL count_first got %0d:%0d want 1:59", remaining_min, remaining_sec);
        end
        checks++;
        repeat (475) @(negedge clk);
        if ({remaining_min, remaining_sec} !== {7'd0, 6'd1} || completeSleep !== 1'b0) begin
            errors++; $display("FAIL count_479 got %0d:%0d cs=%b want 0:1 cs=0", remaining_min, remaining_sec, completeSleep);
        end
        checks++;
        @(negedge clk);
        if ({remaining_min, remaining_sec} !== 13'd0 || completeSleep !== 1'b1) begin
            errors++; $display("FAIL count_480 got %0d:%0d cs=%b want 0:0 cs=1", remaining_min, remaining_sec, completeSleep);
        end
        checks++;
        repeat (10) @(negedge clk);
        if (completeSleep !== 1'b1 || completeSetting !== 1'b1 || remaining_sec !== 6'd0) begin
            errors++; $display("FAIL done_hold got sleep=%b set=%b sec=%0d want 1 1 0", completeSleep, completeSetting, remaining_sec);
        end
        checks++;
        cancel();
        if ({completeSetting, completeSleep} !== 2'b00) begin
            errors++; $display("FAIL done_abort got %b want 00", {completeSetting, completeSleep});
        end
        checks++;
    endtask

    task automatic test_cancel();
        start_entry();
        press_key(2);
        press_sharp();
        enSetting = 1'b0;
        enSleep   = 1'b1;
        repeat (121) @(negedge clk);
        if ({remaining_min, remaining_sec} !== {7'd1, 6'd30}) begin
            errors++; $display("FAIL cancel_pre got %0d:%0d want 1:30", remaining_min, remaining_sec);
        end
        checks++;
        enCancel = 1'b1;
        @(negedge clk);
        enCancel = 1'b0;
        if ({remaining_min, remaining_sec} !== 13'd0) begin
            errors++; $display("FAIL cancel_time got %0d:%0d want 0:0", remaining_min, remaining_sec);
        end
        checks++;
        if ({completeSetting, completeSleep} !== 2'b00) begin
            errors++; $display("FAIL cancel_flags got %b want 00", {completeSetting, completeSleep});
        end
        checks++;
        repeat (8) @(negedge clk);
        if ({remaining_min, remaining_sec, completeSetting} !== 14'd0) begin
            errors++; $display("FAIL cancel_idle got %0d:%0d set=%b want 0:0 0", remaining_min, remaining_sec, completeSetting);
        end
        checks++;
        enSleep = 1'b0;
    endtask

    task automatic test_sharp_and_key();
        start_entry();
        press_key(3);
        @(negedge clk);
        sharp  = 1'b1;
        keypad = 10'd1 << 7;
        @(negedge clk);
        sharp  = 1'b0;
        keypad = 10'd0;
        if (completeSetting !== 1'b1) begin
            errors++; $display("FAIL sk_loaded got %b want 1", completeSetting);
        end
        checks++;
        if (remaining_min !== 7'd3) begin
            errors++; $display("FAIL sk_value got %0d want 3", remaining_min);
        end
        checks++;
        cancel();
    endtask

    task automatic test_reset_mid_count();
        start_entry();
        press_key(1);
        press_sharp();
        enSetting = 1'b0;
        enSleep   = 1'b1;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        if ({completeSetting, completeSleep, entry_err, remaining_min, remaining_sec} !== 16'd0) begin
            errors++; $display("FAIL rst_async got set=%b sleep=%b %0d:%0d want all 0", completeSetting, completeSleep, remaining_min, remaining_sec);
        end
        checks++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        if ({completeSetting, remaining_min, remaining_sec} !== 14'd0) begin
            errors++; $display("FAIL rst_idle got set=%b %0d:%0d want 0 0:0", completeSetting, remaining_min, remaining_sec);
        end
        checks++;
        enSleep = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        init      = 1'b0;
        enSetting = 1'b0;
        enSleep   = 1'b0;
        enCancel  = 1'b0;
        keypad    = 10'd0;
        sharp     = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_entry();
        test_entry_error();
        test_countdown();
        test_cancel();
        test_sharp_and_key();
        test_reset_mid_count();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
